multi_alarm_controller: RTL
===========================

# multi_alarm_controller

Parametrised N-channel alarm controller, successor to the single-alarm time register. Each channel holds an hours/minutes alarm setting adjustable by increment pulses, an enable flag, and a ring/snooze state machine. The block compares every channel against the running time-of-day from the clock's time counter on each minute boundary, and drives per-channel ringing status plus a combined buzzer request. It sits between the time counter and the display/buzzer logic.

## Interface
- NUM_ALARMS, 4, number of alarm channels (1..8)
- SNOOZE_MINUTES, 9, snooze delay in minutes (1..59)
- RING_TIMEOUT_MINUTES, 10, minutes of ringing before automatic stop (1..59)
- START_MINUTES, 0, reset alarm minute for all channels (0..59)
- START_HOURS, 0, reset alarm hour for all channels (0..23)

- i_Clk  in  1  system clock
- i_Reset  in  1  asynchronous, active-low reset
- i_Time_Minutes  in  11  current minutes-of-day, 0..1439
- i_Minute_Tick  in  1  one-cycle pulse, asserted in the first cycle i_Time_Minutes holds a new value
- i_Sel  in  $clog2(NUM_ALARMS) (min 1)  channel addressed by edit inputs
- i_Minutes_Inc  in  1  one-cycle pulse: selected alarm minute +1
- i_Hours_Inc  in  1  one-cycle pulse: selected alarm hour +1
- i_Enable_Toggle  in  1  one-cycle pulse: invert selected channel enable
- i_Snooze  in  1  one-cycle pulse, applies to all ringing channels
- i_Dismiss  in  1  one-cycle pulse, applies to all ringing and snoozed channels
- o_Alarm_Minutes  out  11  selected channel's alarm setting as minutes-of-day
- o_Enabled  out  NUM_ALARMS  per-channel enable
- o_Ringing  out  NUM_ALARMS  per-channel RINGING state
- o_Snoozed  out  NUM_ALARMS  per-channel SNOOZED state
- o_Buzzer  out  1  OR of o_Ringing

## Operation
- Per-channel registers: hour (0..23), minute (0..59), enable, state, 11-bit wake target, 6-bit ring counter.
- Edits apply only to channel i_Sel. When i_Sel >= NUM_ALARMS, edits are ignored. Minute wraps 59->0 with no carry into hour. Hour wraps 23->0.
- Alarm minutes-of-day = hour*60 + minute.
- State IDLE:
  - Goes to RINGING when enable=1, i_Minute_Tick=1 and i_Time_Minutes equals the alarm minutes-of-day. Ring counter clears to 0.
- State RINGING:
  - i_Dismiss goes to IDLE.
  - Otherwise, i_Snooze goes to SNOOZED. Wake target = (i_Time_Minutes + SNOOZE_MINUTES) mod 1440.
  - Otherwise, on i_Minute_Tick the ring counter increments. When it reaches RING_TIMEOUT_MINUTES the channel goes to IDLE.
- State SNOOZED:
  - i_Dismiss goes to IDLE.
  - i_Minute_Tick with i_Time_Minutes == wake target goes to RINGING. Ring counter clears to 0.
- Any channel whose enable becomes 0 (toggle) goes to IDLE in the same update.
- Editing a ringing or snoozed channel's time does not change its state.
- Precedence within one cycle: disable > dismiss > snooze > tick.
- An alarm edited to the current minute does not ring until that minute next recurs; matches occur only on i_Minute_Tick.

## Timing
- All outputs are registered or decode registered state. There is no combinational input-to-output path except o_Alarm_Minutes (mux on i_Sel).
- The effect of any input pulse sampled at edge k is visible after edge k.
- o_Ringing rises in the cycle after the matching i_Minute_Tick. o_Buzzer follows o_Ringing with the same latency.
- When an edit pulse and a matching tick fall in the same cycle, the comparison uses the pre-edit value.
- Reset (asynchronous assert, synchronous deassert handled upstream) forces:
  - every channel to hour=START_HOURS, minute=START_MINUTES, enable=0, state IDLE, counters 0;
  - o_Ringing=0, o_Snoozed=0, o_Enabled=0, o_Buzzer=0.
- Reset mid-ring aborts the ring immediately.

## Structure
- Package alarm_pkg holds:
  - MINUTES_PER_DAY=1440, MINUTE_W=11;
  - state encoding IDLE=2'd0, RINGING=2'd1, SNOOZED=2'd2;
  - a function for wrap-add modulo 1440.
- Sub-module alarm_channel holds one channel's registers and FSM. The top level instantiates NUM_ALARMS copies with a generate loop, decodes i_Sel into per-channel edit strobes, muxes o_Alarm_Minutes, and ORs o_Buzzer.

## Test plan
- Reset, then 60 i_Minutes_Inc pulses and 24 i_Hours_Inc pulses on channel 0 -> o_Alarm_Minutes returns to 0 after each wrap, with no hour carry (value 0 after 60 minute pulses).
- Channel 1 set to 07:30 and enabled; tick at i_Time_Minutes=450 -> o_Ringing[1]=1 and o_Buzzer=1 next cycle, other bits 0. A tick at 450 with channel 1 disabled -> no ring.
- Channel ringing at 450; i_Snooze -> o_Snoozed=1. Ticks 451..458 -> still snoozed. Tick 459 -> ringing again.
- Channel at 23:55 with SNOOZE_MINUTES=9; snooze at 1435 -> wake target 4, ring on tick at minute 4.
- Ring left alone -> auto-IDLE exactly RINGING_TIMEOUT_MINUTES ticks later. i_Snooze and i_Dismiss in the same cycle -> IDLE.
- Two channels match the same minute -> both ring. Reset asserted mid-ring -> all outputs 0 asynchronously, settings back to START_HOURS/START_MINUTES.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared constants, channel state encoding and minutes-of-day arithmetic
// used by the multi-channel alarm controller.
package alarm_pkg;

  localparam int unsigned MINUTES_PER_DAY = 1440;
  localparam int unsigned MINUTE_W        = 11;
  localparam int unsigned HOUR_W          = 5;
  localparam int unsigned MIN_W           = 6;
  localparam int unsigned CNT_W           = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_e;

  // Add two minutes-of-day values (each < 1440) and wrap past midnight.
  function automatic logic [MINUTE_W-1:0] wrap_add(input logic [MINUTE_W-1:0] a,
                                                   input logic [MINUTE_W-1:0] b);
    logic [MINUTE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (MINUTE_W+1)'(MINUTES_PER_DAY)) begin
      sum = sum - (MINUTE_W+1)'(MINUTES_PER_DAY);
    end
    return sum[MINUTE_W-1:0];
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: hour/minute setting, enable flag and the
// ring/snooze state machine with its wake target and ring counter.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MINUTES       = 9,
  parameter int unsigned RING_TIMEOUT_MINUTES = 10,
  parameter int unsigned START_MINUTES        = 0,
  parameter int unsigned START_HOURS          = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MINUTE_W-1:0] time_minutes,
  input  logic                minute_tick,
  input  logic                minutes_inc,
  input  logic                hours_inc,
  input  logic                enable_toggle,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [MINUTE_W-1:0] alarm_minutes,
  output logic                enabled,
  output logic                ringing,
  output logic                snoozed
);

  localparam logic [MINUTE_W-1:0] MIN_PER_HOUR = MINUTE_W'(60);

  alarm_state_e        state_q, state_d;
  logic [HOUR_W-1:0]   hour_q, hour_d;
  logic [MIN_W-1:0]    minute_q, minute_d;
  logic                enable_q, enable_d;
  logic [MINUTE_W-1:0] wake_q, wake_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                alarm_match;
  logic                wake_match;

  // Matches use the pre-edit setting, so a same-cycle edit cannot trigger a ring.
  assign alarm_minutes = MINUTE_W'(hour_q) * MIN_PER_HOUR + MINUTE_W'(minute_q);
  assign alarm_match   = minute_tick && enable_q && (time_minutes == alarm_minutes);
  assign wake_match    = minute_tick && (time_minutes == wake_q);
  assign cnt_inc       = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wake_d   = wake_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    enable_d = enable_q ^ enable_toggle;

    if (enable_toggle && enable_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (alarm_match) begin
            state_d = RINGING;
            cnt_d   = '0;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_d = IDLE;
          end else if (snooze) begin
            state_d = SNOOZED;
            wake_d  = wrap_add(time_minutes, MINUTE_W'(SNOOZE_MINUTES));
          end else if (minute_tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(RING_TIMEOUT_MINUTES)) begin
              state_d = IDLE;
            end
          end
        end
        SNOOZED: begin
          if (dismiss) begin
            state_d = IDLE;
          end else if (wake_match) begin
            state_d = RINGING;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Setting edits wrap independently; no minute-to-hour carry.
    if (minutes_inc) begin
      minute_d = (minute_q == MIN_W'(59)) ? '0 : minute_q + MIN_W'(1);
    end
    if (hours_inc) begin
      hour_d = (hour_q == HOUR_W'(23)) ? '0 : hour_q + HOUR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hour_q   <= HOUR_W'(START_HOURS);
      minute_q <= MIN_W'(START_MINUTES);
      enable_q <= 1'b0;
      wake_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      enable_q <= enable_d;
      wake_q   <= wake_d;
      cnt_q    <= cnt_d;
    end
  end

  assign enabled = enable_q;
  assign ringing = (state_q == RINGING);
  assign snoozed = (state_q == SNOOZED);

endmodule

// File: rtl/multi_alarm_controller.sv
// N-channel alarm controller: decodes the edit select into per-channel
// strobes, muxes the selected setting and combines ringing into the buzzer.
module multi_alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS           = 4,
  parameter int unsigned SNOOZE_MINUTES       = 9,
  parameter int unsigned RING_TIMEOUT_MINUTES = 10,
  parameter int unsigned START_MINUTES        = 0,
  parameter int unsigned START_HOURS          = 0,
  localparam int unsigned SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic [MINUTE_W-1:0]   i_Time_Minutes,
  input  logic                  i_Minute_Tick,
  input  logic [SEL_W-1:0]      i_Sel,
  input  logic                  i_Minutes_Inc,
  input  logic                  i_Hours_Inc,
  input  logic                  i_Enable_Toggle,
  input  logic                  i_Snooze,
  input  logic                  i_Dismiss,
  output logic [MINUTE_W-1:0]   o_Alarm_Minutes,
  output logic [NUM_ALARMS-1:0] o_Enabled,
  output logic [NUM_ALARMS-1:0] o_Ringing,
  output logic [NUM_ALARMS-1:0] o_Snoozed,
  output logic                  o_Buzzer
);

  logic [MINUTE_W-1:0] alarm_min [NUM_ALARMS];

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    logic sel_hit;
    assign sel_hit = (i_Sel == SEL_W'(g));

    alarm_channel #(
      .SNOOZE_MINUTES      (SNOOZE_MINUTES),
      .RING_TIMEOUT_MINUTES(RING_TIMEOUT_MINUTES),
      .START_MINUTES       (START_MINUTES),
      .START_HOURS         (START_HOURS)
    ) u_ch (
      .clk          (i_Clk),
      .rst_n        (i_Reset),
      .time_minutes (i_Time_Minutes),
      .minute_tick  (i_Minute_Tick),
      .minutes_inc  (i_Minutes_Inc && sel_hit),
      .hours_inc    (i_Hours_Inc && sel_hit),
      .enable_toggle(i_Enable_Toggle && sel_hit),
      .snooze       (i_Snooze),
      .dismiss      (i_Dismiss),
      .alarm_minutes(alarm_min[g]),
      .enabled      (o_Enabled[g]),
      .ringing      (o_Ringing[g]),
      .snoozed      (o_Snoozed[g])
    );
  end

  // Out-of-range selects read back as zero.
  always_comb begin
    o_Alarm_Minutes = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (i_Sel == SEL_W'(i)) begin
        o_Alarm_Minutes = alarm_min[i];
      end
    end
  end

  assign o_Buzzer = |o_Ringing;

endmodule
